// File: rtl/osd_coin_sequencer.sv
// OSD/keyboard coin-start-reset sequencer for the Midway 8080 core.
// Define MIDWAY_KBD_EN to let the kbd_* keys raise requests.
module osd_coin_sequencer #(
   parameter int PULSE_CYC = 5_000_000,
   parameter int GAP_CYC   = 2_500_000,
   parameter int CNT_W     = 23
) (
   input  logic        clk_sys,
   input  logic        rst_n,
   input  logic [31:0] status,
   input  logic        kbd_coin,
   input  logic        kbd_start1,
   input  logic        kbd_start2,
   output logic        coin_o,
   output logic        start1_o,
   output logic        start2_o,
   output logic        core_rst_n,
   output logic        busy
);

   localparam logic [1:0] S_RESET = 2'd0;
   localparam logic [1:0] S_IDLE  = 2'd1;
   localparam logic [1:0] S_PULSE = 2'd2;
   localparam logic [1:0] S_GAP   = 2'd3;

   localparam logic [CNT_W-1:0] P_LD = CNT_W'(PULSE_CYC - 1);
   localparam logic [CNT_W-1:0] G_LD = CNT_W'(GAP_CYC - 1);
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

   // Channel bit order everywhere: [0] coin, [1] start1, [2] start2, [3] reset.
   logic [3:0] osd_cur;
   logic [3:0] osd_q;
   logic [3:0] osd_e_q;
   logic [2:0] kbd_q;
   logic [2:0] kbd_e_q;
   logic [3:0] req;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       ch_q, ch_d;
   logic [1:0]       coin_pend_q, coin_pend_d;
   logic             s1_pend_q, s1_pend_d;
   logic             s2_pend_q, s2_pend_d;
   logic             rst_pend_q, rst_pend_d;
   logic [2:0]       srv;
   logic             go_rst;
   logic             clr;
   logic [2:0]       coin_sum;

   wire unused_status = ^{status[31:6], status[4], status[0]};

   assign osd_cur = {status[5], status[3], status[2], status[1]};

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         osd_q   <= '0;
         osd_e_q <= '0;
      end else begin
         osd_q   <= osd_cur;
         osd_e_q <= osd_cur & ~osd_q;
      end
   end

`ifdef MIDWAY_KBD_EN
   logic [2:0] kbd_cur;
   assign kbd_cur = {kbd_start2, kbd_start1, kbd_coin};

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         kbd_q   <= '0;
         kbd_e_q <= '0;
      end else begin
         kbd_q   <= kbd_cur;
         kbd_e_q <= kbd_cur & ~kbd_q;
      end
   end
`else
   wire unused_kbd = ^{kbd_start2, kbd_start1, kbd_coin, kbd_q};
   assign kbd_q   = '0;
   assign kbd_e_q = '0;
`endif

   assign req = osd_e_q | {1'b0, kbd_e_q};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ch_d    = ch_q;
      srv     = '0;
      go_rst  = 1'b0;
      unique case (state_q)
         S_RESET: begin
            if (cnt_q == '0) state_d = S_IDLE;
            else             cnt_d   = cnt_q - ONE;
         end
         S_IDLE: begin
            if (rst_pend_q)              go_rst = 1'b1;
            else if (coin_pend_q != 2'd0) srv   = 3'b001;
            else if (s1_pend_q)          srv    = 3'b010;
            else if (s2_pend_q)          srv    = 3'b100;
            if (|srv) begin
               state_d = S_PULSE;
               ch_d    = srv;
               cnt_d   = P_LD;
            end
         end
         S_PULSE: begin
            if (rst_pend_q) go_rst = 1'b1;
            else if (cnt_q == '0) begin
               state_d = S_GAP;
               cnt_d   = G_LD;
            end else cnt_d = cnt_q - ONE;
         end
         default: begin
            if (rst_pend_q)         go_rst  = 1'b1;
            else if (cnt_q == '0)   state_d = S_IDLE;
            else                    cnt_d   = cnt_q - ONE;
         end
      endcase
      if (go_rst) begin
         state_d = S_RESET;
         cnt_d   = P_LD;
      end
   end

   // Anything arriving while in or entering RESET is thrown away.
   always_comb begin
      clr      = (state_q == S_RESET) | go_rst;
      coin_sum = {1'b0, coin_pend_q} + {2'b0, req[0]} - {2'b0, srv[0]};
      if (clr) begin
         coin_pend_d = '0;
         s1_pend_d   = 1'b0;
         s2_pend_d   = 1'b0;
         rst_pend_d  = 1'b0;
      end else begin
         coin_pend_d = coin_sum[2] ? 2'd3 : coin_sum[1:0];
         s1_pend_d   = (s1_pend_q & ~srv[1]) | req[1];
         s2_pend_d   = (s2_pend_q & ~srv[2]) | req[2];
         rst_pend_d  = rst_pend_q | req[3];
      end
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_RESET;
         cnt_q       <= P_LD;
         ch_q        <= '0;
         coin_pend_q <= '0;
         s1_pend_q   <= 1'b0;
         s2_pend_q   <= 1'b0;
         rst_pend_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ch_q        <= ch_d;
         coin_pend_q <= coin_pend_d;
         s1_pend_q   <= s1_pend_d;
         s2_pend_q   <= s2_pend_d;
         rst_pend_q  <= rst_pend_d;
      end
   end

   assign coin_o     = (state_q == S_PULSE) & ch_q[0];
   assign start1_o   = (state_q == S_PULSE) & ch_q[1];
   assign start2_o   = (state_q == S_PULSE) & ch_q[2];
   assign core_rst_n = (state_q != S_RESET);
   assign busy       = (state_q != S_IDLE) | (coin_pend_q != 2'd0)
                     | s1_pend_q | s2_pend_q | rst_pend_q;

endmodule

// File: tb/tb_osd_coin_sequencer.sv
// Randomized bench for osd_coin_sequencer against a cycle-level reference
// model of the request queue / pulse schedule (PULSE=8, GAP=4).
module tb_osd_coin_sequencer;

   localparam int P = 8;
   localparam int G = 4;
`ifdef MIDWAY_KBD_EN
   localparam bit KBD = 1'b1;
`else
   localparam bit KBD = 1'b0;
`endif

   localparam int PH_RST   = 0;
   localparam int PH_IDLE  = 1;
   localparam int PH_PULSE = 2;
   localparam int PH_GAP   = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] status;
   logic        kc, k1, k2;
   logic        coin_o, start1_o, start2_o, core_rst_n, busy;

   int    n_chk = 0;
   int    n_pass = 0;
   string scn = "reset";

   osd_coin_sequencer #(.PULSE_CYC(P), .GAP_CYC(G), .CNT_W(4)) dut (
      .clk_sys   (clk),
      .rst_n     (rst_n),
      .status    (status),
      .kbd_coin  (kc),
      .kbd_start1(k1),
      .kbd_start2(k2),
      .coin_o    (coin_o),
      .start1_o  (start1_o),
      .start2_o  (start2_o),
      .core_rst_n(core_rst_n),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s t=%0t got=%b expected=%b", tag, $time, obs, exp);
   endtask

   // Reference model: phase + cycles remaining, coin count and flags.
   int ph, rem, ch, cpend;
   bit s1p, s2p, rp;
   bit [6:0] prv, edl;

   function automatic void m_reset();
      ph = PH_RST; rem = P; ch = 0; cpend = 0;
      s1p = 0; s2p = 0; rp = 0; prv = '0; edl = '0;
   endfunction

   function automatic void m_step(input bit [6:0] cur);
      bit [6:0] e;
      bit [3:0] a;
      bit was_rst, to_rst;
      int srv;
      e = cur & ~prv;
      if (!KBD) e[6:4] = '0;
      a = {edl[3], edl[2] | edl[6], edl[1] | edl[5], edl[0] | edl[4]};
      edl = e;
      prv = cur;
      was_rst = (ph == PH_RST);
      to_rst = 0;
      srv = -1;
      case (ph)
         PH_RST: if (rem == 1) ph = PH_IDLE; else rem--;
         PH_IDLE: begin
            if (rp) to_rst = 1;
            else if (cpend > 0) srv = 0;
            else if (s1p) srv = 1;
            else if (s2p) srv = 2;
            if (srv >= 0) begin ph = PH_PULSE; rem = P; ch = srv; end
         end
         PH_PULSE: begin
            if (rp) to_rst = 1;
            else if (rem == 1) begin ph = PH_GAP; rem = G; end
            else rem--;
         end
         default: begin
            if (rp) to_rst = 1;
            else if (rem == 1) ph = PH_IDLE;
            else rem--;
         end
      endcase
      if (was_rst || to_rst) begin
         cpend = 0; s1p = 0; s2p = 0; rp = 0;
      end else begin
         cpend = cpend + int'(a[0]) - ((srv == 0) ? 1 : 0);
         if (cpend > 3) cpend = 3;
         s1p = (s1p && srv != 1) || a[1];
         s2p = (s2p && srv != 2) || a[2];
         rp  = rp || a[3];
      end
      if (to_rst) begin ph = PH_RST; rem = P; end
   endfunction

   function automatic logic [7:0] m_out();
      bit pl;
      pl = (ph == PH_PULSE);
      return {3'b000, pl && ch == 0, pl && ch == 1, pl && ch == 2,
              ph != PH_RST,
              ph != PH_IDLE || cpend != 0 || s1p || s2p || rp};
   endfunction

   task automatic compare();
      logic [2:0] p;
      p = {coin_o, start1_o, start2_o};
      chk(scn, {3'b000, p, core_rst_n, busy}, m_out());
      chk("excl", {7'd0, ($countones(p) <= 1) && !(!core_rst_n && |p)}, 8'd1);
   endtask

   task automatic cyc();
      bit [6:0] cur;
      @(posedge clk);
      cur = {k2, k1, kc, status[5], status[3], status[2], status[1]};
      if (rst_n) m_step(cur);
      else m_reset();
      @(negedge clk);
      compare();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic hit(input logic [31:0] m);
      status = status | m;
      cyc();
      status = status & ~m;
   endtask

   task automatic async_rst();
      #2;
      rst_n = 1'b0;
      m_reset();
      #1;
      chk("async", {3'b000, coin_o, start1_o, start2_o, core_rst_n, busy}, m_out());
      idle(2);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; status = '0; kc = 0; k1 = 0; k2 = 0;
      m_reset();
      @(negedge clk);
      compare();
      idle(2);

      scn = "pwrup"; rst_n = 1'b1; idle(12);
      scn = "coin1"; hit(32'h2); idle(16);
      scn = "coinq";
      for (int i = 0; i < 5; i++) begin hit(32'h2); cyc(); end
      idle(60);
      scn = "prio"; hit(32'hE); idle(45);
      scn = "abort"; hit(32'h4); idle(4);
      hit(32'h20); cyc(); hit(32'h8); idle(20);
      scn = "kbd"; kc = 1; idle(2); kc = 0; idle(16);
      scn = "rstpulse"; hit(32'h2); idle(5); async_rst(); idle(12);

      scn = "rand";
      for (int i = 0; i < 3000; i++) begin
         foreach (status[b]) begin
            if (b == 5) begin
               if ($urandom_range(0, 59) == 0) status[b] = ~status[b];
            end else if ($urandom_range(0, 7) == 0) status[b] = ~status[b];
         end
         if ($urandom_range(0, 9) == 0) kc = ~kc;
         if ($urandom_range(0, 11) == 0) k1 = ~k1;
         if ($urandom_range(0, 13) == 0) k2 = ~k2;
         if ($urandom_range(0, 499) == 0) async_rst();
         else cyc();
      end
      status = '0; kc = 0; k1 = 0; k2 = 0;
      scn = "drain"; idle(80);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
